// File: rtl/pll_loop_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pll_lf_pkg
//  Description : Shared constants and helpers for the PLL loop filter:
//                default parameter values, lock-counter width and a
//                saturating resize function used by the saturating adders.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_lf_pkg;

   localparam int PLL_LF_W      = 17;
   localparam int PLL_LF_GW     = 16;
   localparam int PLL_LF_AW     = 32;
   localparam int PLL_LF_OW     = 32;
   localparam int PLL_LF_PSH    = 8;
   localparam int PLL_LF_ISH    = 12;
   localparam int PLL_LF_LOCK_N = 64;

   // Bits needed to count 0..n inclusive.
   function automatic int lock_cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   // Clamp a 64-bit signed value into the range of an n-bit signed number.
   function automatic logic signed [63:0] sat_resize(input logic signed [63:0] x,
                                                     input int n);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      else
         return x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pll_loop_filter_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : pll_sat_add
//  Description : Combinational signed adder whose result is clamped to the
//                O_W-bit signed range instead of wrapping. Operand widths
//                must stay below 64 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_sat_add
   import pll_lf_pkg::*;
#(
   parameter int A_W = 32,
   parameter int B_W = 32,
   parameter int O_W = 32
)(
   input  logic signed [A_W-1:0] i_a,
   input  logic signed [B_W-1:0] i_b,
   output logic signed [O_W-1:0] o_sum
);

   logic signed [63:0] w_a;
   logic signed [63:0] w_b;

   // Sign-extend both operands so the raw sum can never overflow.
   assign w_a   = 64'(i_a);
   assign w_b   = 64'(i_b);
   assign o_sum = O_W'(sat_resize(w_a + w_b, O_W));

endmodule
`default_nettype wire

// File: rtl/pll_loop_filter.sv
`default_nettype none
// ============================================================================
//  Module      : pll_loop_filter
//  Description : Three-stage pipelined PI loop filter. Stage 1 multiplies the
//                phase error by the gains, stage 2 scales and integrates with
//                saturation, stage 3 adds the proportional term and the
//                center-frequency offset. Build macro PLL_LF_LOCK_DETECT_EN
//                adds a lock detector; without it o_locked is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_loop_filter
   import pll_lf_pkg::*;
#(
   parameter int W      = PLL_LF_W,
   parameter int GW     = PLL_LF_GW,
   parameter int AW     = PLL_LF_AW,
   parameter int OW     = PLL_LF_OW,
   parameter int PSH    = PLL_LF_PSH,
   parameter int ISH    = PLL_LF_ISH,
   parameter int LOCK_N = PLL_LF_LOCK_N
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [W-1:0]  i_err_in,
   input  logic                 i_strobe_in,
   input  logic [GW-1:0]        i_kp,
   input  logic [GW-1:0]        i_ki,
   input  logic signed [OW-1:0] i_offset,
   input  logic                 i_loop_en,
   input  logic                 i_int_clear,
   input  logic [W-2:0]         i_lock_thresh,
   output logic signed [OW-1:0] o_freq_out,
   output logic                 o_strobe_out,
   output logic                 o_locked
);

   // Product width: signed error times zero-extended unsigned gain.
   localparam int c_PW = W + GW + 1;

   logic signed [c_PW-1:0] w_err_x;
   logic signed [c_PW-1:0] w_kp_x;
   logic signed [c_PW-1:0] w_ki_x;
   logic signed [c_PW-1:0] w_p_term;
   logic signed [c_PW-1:0] w_i_inc;
   logic signed [AW-1:0]   w_acc_next;
   logic signed [OW-1:0]   w_acc_p;
   logic signed [OW-1:0]   w_out_sum;

   logic signed [c_PW-1:0] r_p_prod;
   logic signed [c_PW-1:0] r_i_prod;
   logic                   r_v1;
   logic                   r_clr1;
   logic signed [c_PW-1:0] r_p_term;
   logic signed [AW-1:0]   r_acc;
   logic                   r_v2;
   logic signed [OW-1:0]   r_freq;
   logic                   r_v3;

   assign w_err_x = c_PW'(i_err_in);
   assign w_kp_x  = c_PW'({1'b0, i_kp});
   assign w_ki_x  = c_PW'({1'b0, i_ki});

   // Stage 1: gain products, captured together with the clear request.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1     <= 1'b0;
         r_clr1   <= 1'b0;
         r_p_prod <= '0;
         r_i_prod <= '0;
      end else begin
         r_v1 <= i_strobe_in;
         if (i_strobe_in) begin
            r_p_prod <= w_err_x * w_kp_x;
            r_i_prod <= w_err_x * w_ki_x;
            r_clr1   <= i_int_clear;
         end
      end
   end

   // Arithmetic shifts floor toward minus infinity.
   assign w_p_term = r_p_prod >>> PSH;
   assign w_i_inc  = r_i_prod >>> ISH;

   pll_sat_add #(.A_W(AW), .B_W(c_PW), .O_W(AW)) u_int_add (
      .i_a   (r_acc),
      .i_b   (w_i_inc),
      .o_sum (w_acc_next)
   );

   // Stage 2: integrator update; a clear overrides integration and loop_en.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v2     <= 1'b0;
         r_p_term <= '0;
         r_acc    <= '0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_p_term <= w_p_term;
            if (r_clr1)
               r_acc <= '0;
            else if (i_loop_en)
               r_acc <= w_acc_next;
         end
      end
   end

   pll_sat_add #(.A_W(AW), .B_W(c_PW), .O_W(OW)) u_pi_add (
      .i_a   (r_acc),
      .i_b   (r_p_term),
      .o_sum (w_acc_p)
   );

   pll_sat_add #(.A_W(OW), .B_W(OW), .O_W(OW)) u_out_add (
      .i_a   (i_offset),
      .i_b   (w_acc_p),
      .o_sum (w_out_sum)
   );

   // Stage 3: output word, held between strobes; open loop passes offset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v3   <= 1'b0;
         r_freq <= '0;
      end else begin
         r_v3 <= r_v2;
         if (r_v2)
            r_freq <= i_loop_en ? w_out_sum : i_offset;
      end
   end

   assign o_freq_out   = r_freq;
   assign o_strobe_out = r_v3;

`ifdef PLL_LF_LOCK_DETECT_EN
   localparam int              c_CW     = lock_cnt_width(LOCK_N);
   localparam logic [c_CW-1:0] c_LOCK_N = c_CW'(LOCK_N);

   logic [W-1:0]    w_abs;
   logic            w_in_win;
   logic [c_CW-1:0] w_cnt_next;
   logic [c_CW-1:0] r_lock_cnt;
   logic            r_locked;

   // The most negative error keeps its MSB after negation, marking it out of window.
   assign w_abs      = i_err_in[W-1] ? (~i_err_in + W'(1)) : i_err_in;
   assign w_in_win   = ~w_abs[W-1] & (w_abs[W-2:0] < i_lock_thresh);
   assign w_cnt_next = (r_lock_cnt == c_LOCK_N) ? r_lock_cnt : r_lock_cnt + c_CW'(1);

   // Lock detector: count consecutive in-window samples, drop on any miss.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
      end else if (i_strobe_in) begin
         if (w_in_win) begin
            r_lock_cnt <= w_cnt_next;
            r_locked   <= (w_cnt_next == c_LOCK_N);
         end else begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
         end
      end
   end

   assign o_locked = r_locked;
`else
   logic w_unused_lock;
   assign w_unused_lock = ^i_lock_thresh;
   assign o_locked      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_loop_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_loop_filter
//  Description : Self-checking bench for pll_loop_filter. A per-cycle input
//                history feeds a sample-level reference model whose results
//                are queued; a monitor pops and compares on strobe_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_loop_filter;

   localparam int W      = 17;
   localparam int GW     = 16;
   localparam int AW     = 32;
   localparam int OW     = 32;
   localparam int PSH    = 8;
   localparam int ISH    = 12;
   localparam int LOCK_N = 64;
   localparam int NCYC   = 16384;
`ifdef PLL_LF_LOCK_DETECT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic signed [W-1:0]  i_err_in = '0;
   logic                 i_strobe_in = 1'b0;
   logic [GW-1:0]        i_kp = '0;
   logic [GW-1:0]        i_ki = '0;
   logic signed [OW-1:0] i_offset = '0;
   logic                 i_loop_en = 1'b1;
   logic                 i_int_clear = 1'b0;
   logic [W-2:0]         i_lock_thresh = '0;
   logic signed [OW-1:0] o_freq_out;
   logic                 o_strobe_out;
   logic                 o_locked;

   pll_loop_filter dut (
      .clk           (clk),
      .reset         (reset),
      .i_err_in      (i_err_in),
      .i_strobe_in   (i_strobe_in),
      .i_kp          (i_kp),
      .i_ki          (i_ki),
      .i_offset      (i_offset),
      .i_loop_en     (i_loop_en),
      .i_int_clear   (i_int_clear),
      .i_lock_thresh (i_lock_thresh),
      .o_freq_out    (o_freq_out),
      .o_strobe_out  (o_strobe_out),
      .o_locked      (o_locked)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Input history, one entry per clock edge
   bit     h_rst [NCYC];
   bit     h_stb [NCYC];
   bit     h_clr [NCYC];
   bit     h_en  [NCYC];
   longint h_err [NCYC];
   longint h_kp  [NCYC];
   longint h_ki  [NCYC];
   longint h_off [NCYC];

   // Reference model state
   longint m_acc  = 0;
   longint m_freq = 0;
   int     m_lcnt = 0;
   bit     m_lk   = 1'b0;

   typedef struct {
      int     tag;
      longint val;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;

   function automatic longint sat(input longint x, input int n);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (n - 1)) - 1;
      lo = -hi - 1;
      return (x > hi) ? hi : ((x < lo) ? lo : x);
   endfunction

   // Drive one clock's inputs and advance the reference model to that edge.
   task automatic step(input bit rst, input bit stb, input longint err,
                       input longint kp, input longint ki, input bit clr,
                       input bit en, input longint off, input int thr);
      int     c;
      int     s;
      longint ab;
      longint pt;
      longint ii;
      @(negedge clk);
      c = cyc;
      if (c >= NCYC) begin
         $display("FAIL history_overflow cycle %0d limit %0d", c, NCYC);
         $fatal(1, "bench history exhausted");
      end
      reset         = rst;
      i_strobe_in   = stb;
      i_err_in      = W'(err);
      i_kp          = GW'(kp);
      i_ki          = GW'(ki);
      i_int_clear   = clr;
      i_loop_en     = en;
      i_offset      = OW'(off);
      i_lock_thresh = (W-1)'(thr);
      h_rst[c] = rst;  h_stb[c] = stb;  h_clr[c] = clr;  h_en[c] = en;
      h_err[c] = longint'(i_err_in);
      h_kp[c]  = kp;   h_ki[c]  = ki;   h_off[c] = longint'(i_offset);

      if (rst) begin
         m_acc = 0; m_freq = 0; m_lcnt = 0; m_lk = 1'b0;
      end else if (stb && LOCK_EN) begin
         ab = (h_err[c] < 0) ? -h_err[c] : h_err[c];
         if (ab < longint'(thr)) begin
            if (m_lcnt < LOCK_N) m_lcnt++;
            m_lk = (m_lcnt == LOCK_N);
         end else begin
            m_lcnt = 0;
            m_lk   = 1'b0;
         end
      end

      // A sample survives only if no reset hits it during its three cycles.
      s = c - 2;
      if (s >= 0 && h_stb[s] && !h_rst[s] && !h_rst[s+1] && !h_rst[c]) begin
         pt = (h_err[s] * h_kp[s]) >>> PSH;
         ii = (h_err[s] * h_ki[s]) >>> ISH;
         if (h_clr[s])
            m_acc = 0;
         else if (h_en[s+1])
            m_acc = sat(m_acc + ii, AW);
         m_freq = h_en[c] ? sat(h_off[c] + sat(m_acc + pt, OW), OW) : h_off[c];
         q.push_back('{tag: c, val: m_freq});
      end
   endtask

   task automatic idle(input int n, input bit en, input longint off);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0, en, off, 0);
   endtask

   task automatic rand_step();
      logic signed [W-1:0] e;
      longint err;
      bit     rst;
      bit     stb;
      e   = W'($urandom);
      err = ($urandom_range(0, 1) == 0) ? longint'(e) : longint'($urandom_range(0, 200)) - 100;
      rst = ($urandom_range(0, 199) == 0);
      stb = ($urandom_range(0, 3) != 0);
      step(rst, stb, err, longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) != 0),
           longint'($signed(32'($urandom))) >>> $urandom_range(0, 20),
           int'($urandom_range(0, 65535)));
   endtask

   // Monitor: compares registered outputs just after each active edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      checks++;
      if (o_locked !== m_lk) begin
         errors++;
         $display("FAIL locked cycle %0d actual %b required %b", cyc - 1, o_locked, m_lk);
      end
      if (o_strobe_out === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe cycle %0d actual freq %0d required no strobe", cyc - 1, o_freq_out);
         end else begin
            e = q.pop_front();
            if (e.tag != cyc - 1 || o_freq_out !== OW'(e.val)) begin
               errors++;
               $display("FAIL freq_out cycle %0d actual %0d required %0d (due cycle %0d)",
                        cyc - 1, o_freq_out, e.val, e.tag);
            end
         end
      end else begin
         checks++;
         if (o_strobe_out !== 1'b0) begin
            errors++;
            $display("FAIL strobe_out cycle %0d actual %b required 0", cyc - 1, o_strobe_out);
         end
         while (q.size() > 0 && q[0].tag < cyc - 1) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe cycle %0d actual none required %0d", e.tag, e.val);
         end
         checks++;
         if (o_freq_out !== OW'(m_freq)) begin
            errors++;
            $display("FAIL freq_hold cycle %0d actual %0d required %0d", cyc - 1, o_freq_out, m_freq);
         end
      end
   end

   initial begin
      // Reset
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
      // Proportional path
      step(1'b0, 1'b1, 1000, 256, 0, 1'b0, 1'b1, 0, 0);
      idle(3, 1'b1, 0);
      step(1'b0, 1'b1, -1000, 256, 0, 1'b0, 1'b1, 0, 0);
      idle(3, 1'b1, 0);
      // Integral path, then clear
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 100, 0, 4096, 1'b0, 1'b1, 0, 0);
         idle(2, 1'b1, 0);
      end
      step(1'b0, 1'b1, 100, 0, 4096, 1'b1, 1'b1, 0, 0);
      idle(3, 1'b1, 0);
      // Positive integrator saturation, then offset saturation
      for (int i = 0; i < 2200; i++) step(1'b0, 1'b1, 65535, 0, 65535, 1'b0, 1'b1, 0, 0);
      step(1'b0, 1'b1, 1000, 256, 0, 1'b0, 1'b1, 64'sh7FFFFF00, 0);
      idle(3, 1'b1, 64'sh7FFFFF00);
      // Negative saturation from a cleared integrator
      step(1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b1, 0, 0);
      for (int i = 0; i < 2200; i++) step(1'b0, 1'b1, -65536, 0, 65535, 1'b0, 1'b1, -5, 0);
      idle(3, 1'b1, 0);
      // Open loop: integrator held, output follows offset
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 700 * i, 300, 4000, 1'b0, 1'b0, 12345, 0);
      idle(3, 1'b0, 12345);
      step(1'b0, 1'b1, 50, 256, 4096, 1'b0, 1'b1, 0, 0);
      idle(3, 1'b1, 0);
      // Reset with two samples in flight
      step(1'b0, 1'b1, 300, 256, 4096, 1'b0, 1'b1, 77, 0);
      step(1'b0, 1'b1, 400, 256, 4096, 1'b0, 1'b1, 77, 0);
      step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 77, 0);
      idle(4, 1'b1, 77);
      // Lock acquisition and loss
      step(1'b0, 1'b1, 60, 0, 0, 1'b0, 1'b1, 0, 50);
      for (int i = 0; i < 66; i++) step(1'b0, 1'b1, 10, 0, 0, 1'b0, 1'b1, 0, 50);
      step(1'b0, 1'b1, 60, 0, 0, 1'b0, 1'b1, 0, 50);
      for (int i = 0; i < 64; i++) step(1'b0, 1'b1, -10, 0, 0, 1'b0, 1'b1, 0, 65535);
      step(1'b0, 1'b1, -65536, 0, 0, 1'b0, 1'b1, 0, 65535);
      idle(3, 1'b1, 0);
      // Back-to-back ramp
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, -500 + 50 * i, 300, 2000, 1'b0, 1'b1, 1000, 0);
      idle(4, 1'b1, 1000);
      // Randomised traffic
      for (int i = 0; i < 3000; i++) rand_step();
      idle(6, 1'b1, 0);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain actual %0d pending required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
